// File: rtl/mux_rr_stream.sv
// N-channel valid/ready stream multiplexer with a single registered output stage.
// Channel selection is either an external index (manual) or a fair rotating pointer (round-robin).
module mux_rr_stream #(
    parameter int WIDTH = 8,
    parameter int N_CH  = 4,
    localparam int SEL_W = $clog2(N_CH)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_CH*WIDTH-1:0]   in_data,
    input  logic [N_CH-1:0]         in_valid,
    output logic [N_CH-1:0]         in_ready,
    input  logic                    mode,
    input  logic [SEL_W-1:0]        sel,
    output logic [WIDTH-1:0]        out_data,
    output logic [SEL_W-1:0]        out_ch,
    output logic                    out_valid,
    input  logic                    out_ready
);

    localparam int PAD_N = 1 << SEL_W;

    logic [WIDTH-1:0]  out_data_q;
    logic [SEL_W-1:0]  out_ch_q;
    logic              out_valid_q;
    logic [SEL_W-1:0]  ptr_q;
    logic [SEL_W-1:0]  ptr_d;

    logic [PAD_N-1:0]  valid_pad;
    logic [SEL_W-1:0]  grant;
    logic              grant_vld;
    logic              load;
    logic              xfer;
    logic [SEL_W:0]    rr_idx;

    // Indices at or above N_CH read as "not valid", so out-of-range selects never grant.
    assign valid_pad = PAD_N'(in_valid);

    assign load = !out_valid_q || out_ready;
    assign xfer = grant_vld && load && !rst;

    always_comb begin
        grant     = '0;
        grant_vld = 1'b0;
        rr_idx    = '0;
        if (!mode) begin
            grant     = sel;
            grant_vld = valid_pad[sel];
        end else begin
            // Walk from the farthest candidate back to ptr so the nearest valid one wins.
            for (int k = N_CH - 1; k >= 0; k--) begin
                rr_idx = {1'b0, ptr_q} + (SEL_W+1)'(k);
                if (rr_idx >= (SEL_W+1)'(N_CH)) begin
                    rr_idx = rr_idx - (SEL_W+1)'(N_CH);
                end
                if (valid_pad[rr_idx[SEL_W-1:0]]) begin
                    grant     = rr_idx[SEL_W-1:0];
                    grant_vld = 1'b1;
                end
            end
        end
    end

    always_comb begin
        in_ready = '0;
        if (xfer) begin
            in_ready = N_CH'(1) << grant;
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (xfer && mode) begin
            ptr_d = (grant == SEL_W'(N_CH - 1)) ? '0 : grant + SEL_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_data_q  <= '0;
            out_ch_q    <= '0;
            out_valid_q <= 1'b0;
            ptr_q       <= '0;
        end else begin
            ptr_q <= ptr_d;
            if (xfer) begin
                out_data_q  <= in_data[grant*WIDTH +: WIDTH];
                out_ch_q    <= grant;
                out_valid_q <= 1'b1;
            end else if (load) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign out_data  = out_data_q;
    assign out_ch    = out_ch_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_mux_rr_stream.sv
// Randomized + directed bench for mux_rr_stream with a queue-based scoreboard and
// an independent monitor; a second 3-channel instance covers out-of-range select.
module tb_mux_rr_stream;

    localparam int W = 8;
    localparam int N = 4;

    typedef struct {
        logic [7:0] d;
        logic [1:0] ch;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] in_data;
    logic [3:0]  in_valid;
    logic [3:0]  in_ready;
    logic        mode;
    logic [1:0]  sel;
    logic [7:0]  out_data;
    logic [1:0]  out_ch;
    logic        out_valid;
    logic        out_ready;

    logic [23:0] in_data3;
    logic [2:0]  in_valid3;
    logic [2:0]  in_ready3;
    logic        mode3;
    logic [1:0]  sel3;
    logic [7:0]  out_data3;
    logic [1:0]  out_ch3;
    logic        out_valid3;
    logic        out_ready3;

    exp_t q[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   ptr_m = 0;

    always #5 clk = ~clk;

    mux_rr_stream #(.WIDTH(W), .N_CH(N)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mode      (mode),
        .sel       (sel),
        .out_data  (out_data),
        .out_ch    (out_ch),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    mux_rr_stream #(.WIDTH(8), .N_CH(3)) u_dut3 (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data3),
        .in_valid  (in_valid3),
        .in_ready  (in_ready3),
        .mode      (mode3),
        .sel       (sel3),
        .out_data  (out_data3),
        .out_ch    (out_ch3),
        .out_valid (out_valid3),
        .out_ready (out_ready3)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One clock of stimulus: drive, predict grant from the rules, check in_ready, record expected word.
    task automatic cycle(input logic [31:0] d, input logic [3:0] v, input logic m,
                         input logic [1:0] s, input logic r);
        int         g;
        bit         ld;
        logic [3:0] exp_rdy;
        @(negedge clk);
        in_data   = d;
        in_valid  = v;
        mode      = m;
        sel       = s;
        out_ready = r;
        #1;
        g = -1;
        if (!m) begin
            if (v[s]) g = int'(s);
        end else begin
            for (int k = 0; k < N; k++) begin
                int c;
                c = (ptr_m + k) % N;
                if (g < 0 && v[c]) g = c;
            end
        end
        ld      = (q.size() == 0) || r;
        exp_rdy = (g >= 0 && ld) ? 4'(1 << g) : 4'b0000;
        check("in_ready", 32'(in_ready), 32'(exp_rdy));
        $display("cyc mode=%0b sel=%0d valid=%b oready=%0b grant=%0d in_ready=%b", m, s, v, r, g, in_ready);
        @(posedge clk);
        #1;
        if (g >= 0 && ld) begin
            q.push_back('{d[g*8 +: 8], 2'(g)});
            if (m) ptr_m = (g + 1) % N;
        end
    endtask

    // Monitor: compares whatever the DUT presents against the head of the scoreboard.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (!rst) begin
                check("out_valid", 32'(out_valid), 32'(q.size() != 0));
                if (q.size() != 0 && out_valid) begin
                    check("out_data", 32'(out_data), 32'(q[0].d));
                    check("out_ch", 32'(out_ch), 32'(q[0].ch));
                    if (out_ready) void'(q.pop_front());
                end
            end
        end
    end

    initial begin
        rst = 1'b1;
        in_data = '0; in_valid = '0; mode = 1'b0; sel = '0; out_ready = 1'b0;
        in_data3 = '0; in_valid3 = '0; mode3 = 1'b0; sel3 = '0; out_ready3 = 1'b0;
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        #2 rst = 1'b0;

        // Manual select of channel 2, then an unselected channel.
        cycle(32'h00A5_0000, 4'b0100, 1'b0, 2'd2, 1'b1);
        cycle(32'h0000_0000, 4'b1101, 1'b0, 2'd1, 1'b1);
        cycle(32'h0000_0000, 4'b0000, 1'b0, 2'd0, 1'b1);

        // Round-robin fairness with all channels valid.
        for (int i = 0; i < 6; i++) cycle(32'h1312_1110, 4'b1111, 1'b1, 2'd0, 1'b1);

        // Skip and wrap: park ptr at 3, then 0011 and 0001.
        cycle(32'h0000_2200, 4'b0100, 1'b1, 2'd0, 1'b1);
        cycle(32'h0000_3130, 4'b0011, 1'b1, 2'd0, 1'b1);
        cycle(32'h0000_3130, 4'b0011, 1'b1, 2'd0, 1'b1);
        cycle(32'h0000_0040, 4'b0001, 1'b1, 2'd0, 1'b1);

        // Backpressure: hold for 3 cycles with ch1 valid, then release.
        cycle(32'h0000_5500, 4'b0010, 1'b0, 2'd1, 1'b1);
        for (int i = 0; i < 3; i++) cycle(32'h0000_6600, 4'b0010, 1'b0, 2'd1, 1'b0);
        cycle(32'h0000_6600, 4'b0010, 1'b0, 2'd1, 1'b1);
        cycle(32'h0000_7700, 4'b0010, 1'b0, 2'd1, 1'b0);

        // Asynchronous reset while a word is held.
        @(negedge clk);
        check("pre_rst_valid", 32'(out_valid), 32'd1);
        #1 rst = 1'b1;
        #1;
        check("arst_out_valid", 32'(out_valid), 32'd0);
        check("arst_out_data", 32'(out_data), 32'd0);
        check("arst_out_ch", 32'(out_ch), 32'd0);
        check("arst_in_ready", 32'(in_ready), 32'd0);
        q.delete();
        ptr_m = 0;
        @(posedge clk);
        #1;
        check("rst_edge_valid", 32'(out_valid), 32'd0);
        check("rst_edge_in_ready", 32'(in_ready), 32'd0);
        #1 rst = 1'b0;

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            cycle($urandom, 4'($urandom), 1'($urandom), 2'($urandom), ($urandom_range(0, 3) != 0));
        end

        // Drain and confirm the scoreboard empties.
        for (int i = 0; i < 3; i++) cycle(32'h0, 4'b0000, 1'b0, 2'd0, 1'b1);
        check("drain_empty", 32'(q.size()), 32'd0);

        // Three-channel instance: sel=3 never grants, sel=2 does.
        @(negedge clk);
        in_data3 = 24'hC3B2A1; in_valid3 = 3'b111; mode3 = 1'b0; sel3 = 2'd3; out_ready3 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("n3_sel3_in_ready", 32'(in_ready3), 32'd0);
            check("n3_sel3_out_valid", 32'(out_valid3), 32'd0);
            @(negedge clk);
        end
        sel3 = 2'd2;
        #1;
        check("n3_sel2_in_ready", 32'(in_ready3), 32'b100);
        @(negedge clk);
        check("n3_sel2_out_valid", 32'(out_valid3), 32'd1);
        check("n3_sel2_out_data", 32'(out_data3), 32'hC3);
        check("n3_sel2_out_ch", 32'(out_ch3), 32'd2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mux_rr_stream.md
Name: mux_rr_stream

Overview:
- Parametrised N-channel, W-bit stream multiplexer. It is the registered successor of the team's 4:1 select mux.
- Each input channel carries a valid/ready handshake. One output carries a registered valid/ready handshake.
- Two selection modes:
  - manual: external select picks the channel.
  - round-robin: a fair rotating pointer picks the channel.
- Sits between multiple producers and a single consumer, e.g. sensor or UART lanes feeding a shared bus.

Parameters:
- WIDTH, 8, data bits per channel.
- N_CH, 4, number of input channels, 2..16.
- SEL_W, $clog2(N_CH), select and channel-index width. Derived; do not override.

Ports:
- clk, input, 1, single clock, rising edge.
- rst, input, 1, asynchronous active-high reset.
- in_data, input, N_CH*WIDTH, channel i occupies bits [i*WIDTH +: WIDTH].
- in_valid, input, N_CH, per-channel valid.
- in_ready, output, N_CH, per-channel ready. At most one bit set (one-hot or zero).
- mode, input, 1, 0 = manual select, 1 = round-robin.
- sel, input, SEL_W, channel index used in manual mode.
- out_data, output, WIDTH, registered output data.
- out_ch, output, SEL_W, index of the channel that supplied out_data.
- out_valid, output, 1, output holds a word.
- out_ready, input, 1, consumer accepts the word.

Behaviour:
- Reset:
  - rst high asynchronously clears out_data=0, out_ch=0, out_valid=0 and the internal round-robin pointer ptr=0.
  - in_ready is forced to all zeros while rst is high.
  - Reset mid-transfer discards the held word. No input handshake completes in the reset cycle.
- Load enable: load = !out_valid || out_ready. This is a single output register with no bubble on back-to-back transfers.
- Grant is combinational from the current cycle's inputs:
  - Manual (mode=0): if sel < N_CH and in_valid[sel], grant = sel. Otherwise there is no grant. sel >= N_CH (non-power-of-2 N_CH) means no grant, never an X or alias.
  - Round-robin (mode=1): grant is the first i with in_valid[i]=1, searching ptr, ptr+1, ..., wrapping modulo N_CH. If no valid, there is no grant.
- Ready: in_ready[grant] = load. All other bits are 0. in_ready must not depend on in_valid of non-granted channels beyond the grant logic.
- Transfer:
  - When granted and load, on the next rising edge: out_data <= in_data[grant], out_ch <= grant, out_valid <= 1. Latency is exactly 1 cycle from input handshake to out_valid.
  - When load and no grant: out_valid <= 0; out_data and out_ch hold.
  - When out_valid and !out_ready: all output registers hold and in_ready is all zero (backpressure).
- Pointer update:
  - Only on a completed input handshake in round-robin mode: ptr <= (grant == N_CH-1) ? 0 : grant+1.
  - ptr does not change in manual mode or on idle cycles.
- Mode/sel changes:
  - They are sampled combinationally every cycle and affect only the next grant. A word already in the output register is never altered.
  - Switching manual -> round-robin resumes from the retained ptr.
- Simultaneous events: an output handshake and a new input handshake in the same cycle is a single-cycle replace. Throughput is 1 word per clock.
- Data width: no arithmetic. All WIDTH bits are passed unmodified. out_ch width is SEL_W.

Test Plan:
- Reset: assert rst mid-stream with out_valid=1 -> out_valid=0, out_data=0x00, out_ch=0 immediately (before the next edge); in_ready=0000 while rst is high.
- Manual mode, N_CH=4, WIDTH=8: sel=2, in_valid=0100, in_data ch2=0xA5, out_ready=1 -> in_ready=0100; next cycle out_data=0xA5, out_ch=2, out_valid=1.
- Manual with invalid or unselected channel: sel=1, in_valid=1101 -> in_ready=0000, out_valid drops to 0 after one cycle. Separately, with N_CH=3 and sel=3 -> no grant ever.
- Round-robin fairness: all four channels valid continuously, data ch i = 0x10+i, out_ready=1 -> out_ch sequence 0,1,2,3,0,1 and out_data 0x10,0x11,0x12,0x13,0x10,0x11, one word per clock.
- Round-robin skip and wrap: ptr=3, in_valid=0011 -> grant ch0 then ch1. ptr after ch1 = 2. Next grant with in_valid=0001 -> ch0 (wrap).
- Backpressure: out_valid=1, out_ready=0 for 3 cycles with ch1 valid -> out_data/out_ch stable and in_ready=0000. out_ready=1 -> ch1 is accepted the same cycle and appears on the next cycle with no gap.
